// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, transmitter and RX FIFO.
//   - character/entry widths and receive-entry field positions
//   - parity-mode encodings
//   - RX capture FSM state type
//   - packRxEntry(): builds a receive entry from receiver outputs
package uart_pkg;

  localparam int UART_DATA_WIDTH     = 9;
  localparam int UART_RX_ENTRY_WIDTH = 11;

  // Receive entry layout: {break, parityError, data[8:0]}
  localparam int ENTRY_DATA_LSB   = 0;
  localparam int ENTRY_DATA_MSB   = 8;
  localparam int ENTRY_PARITY_BIT = 9;
  localparam int ENTRY_BREAK_BIT  = 10;

  typedef enum logic [1:0] {
    PARITY_SPACE = 2'b00,
    PARITY_EVEN  = 2'b01,
    PARITY_ODD   = 2'b10,
    PARITY_MARK  = 2'b11
  } parityMode_t;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_GUARD = 1'b1
  } captureState_t;

  typedef logic [UART_RX_ENTRY_WIDTH-1:0] rxEntry_t;

  function automatic rxEntry_t packRxEntry(
    input logic [UART_DATA_WIDTH-1:0] data,
    input logic                       parityError,
    input logic                       brk
  );
    rxEntry_t entry;
    entry                                 = '0;
    entry[ENTRY_DATA_MSB:ENTRY_DATA_LSB]  = data;
    entry[ENTRY_PARITY_BIT]               = parityError;
    entry[ENTRY_BREAK_BIT]                = brk;
    return entry;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array.
//   clk      - write clock
//   wrEnable - write strobe, wrData stored at wrAddr on the rising edge
//   wrAddr   - write address
//   wrData   - write data
//   rdAddr   - read address
//   rdData   - asynchronous read of the entry at rdAddr
// Storage is not reset; the owner qualifies rdData with its own valid flag.
module fifo_mem #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wrEnable,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output logic [WIDTH-1:0]      rdData
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEnable) begin
      mem[wrAddr] <= wrData;
    end
  end

  // First-word-fall-through needs the head entry without a read cycle.
  assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the host.
//   clk, rst                 - system clock, asynchronous active-low reset
//   rxData/rxValid           - character and dataReceived level from receiver
//   rxParityError/rxBreak    - receiver flags, qualified by rxValid
//   rxAck                    - receiveData pulse, one per consumed character
//   rdData/rdParityError/
//   rdBreak/rdValid          - head entry (first-word-fall-through)
//   rdEnable                 - pop head entry
//   count/full               - fill level and full flag
//   overflow/clearOverflow   - sticky drop indicator and its clear
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [UART_DATA_WIDTH-1:0] rxData,
  input  logic                       rxValid,
  input  logic                       rxParityError,
  input  logic                       rxBreak,
  output logic                       rxAck,
  output logic [UART_DATA_WIDTH-1:0] rdData,
  output logic                       rdParityError,
  output logic                       rdBreak,
  output logic                       rdValid,
  input  logic                       rdEnable,
  output logic [DEPTH_LOG2:0]        count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clearOverflow
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  captureState_t         state;
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   countReg;
  logic                  overflowReg;

  logic     isEmpty;
  logic     isFull;
  logic     capture;
  logic     popFire;
  logic     pushFire;
  rxEntry_t wrEntry;
  rxEntry_t headEntry;

  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == FULL_COUNT);

  // A character is taken only in IDLE; the GUARD cycle masks the receiver's
  // one-cycle lag in dropping rxValid after rxAck.
  assign capture  = (state == CAP_IDLE) && rxValid;
  assign popFire  = rdEnable && !isEmpty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pushFire = capture && (!isFull || popFire);

  assign wrEntry = packRxEntry(rxData, rxParityError, rxBreak);

  // Capture FSM with registered acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CAP_IDLE;
      rxAck <= 1'b0;
    end else begin
      case (state)
        CAP_IDLE: begin
          rxAck <= rxValid;
          if (rxValid) begin
            state <= CAP_GUARD;
          end
        end
        CAP_GUARD: begin
          rxAck <= 1'b0;
          state <= CAP_IDLE;
        end
        default: begin
          rxAck <= 1'b0;
          state <= CAP_IDLE;
        end
      endcase
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushFire, popFire})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
      // Setting takes priority over a simultaneous clear.
      if (capture && !pushFire) begin
        overflowReg <= 1'b1;
      end else if (clearOverflow) begin
        overflowReg <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .WIDTH      (UART_RX_ENTRY_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) uMem (
    .clk      (clk),
    .wrEnable (pushFire),
    .wrAddr   (wrPtr),
    .wrData   (wrEntry),
    .rdAddr   (rdPtr),
    .rdData   (headEntry)
  );

  // Head fields are forced to zero while empty so stale storage never leaks.
  assign rdValid       = !isEmpty;
  assign rdData        = rdValid ? headEntry[ENTRY_DATA_MSB:ENTRY_DATA_LSB] : '0;
  assign rdParityError = rdValid & headEntry[ENTRY_PARITY_BIT];
  assign rdBreak       = rdValid & headEntry[ENTRY_BREAK_BIT];
  assign count         = countReg;
  assign full          = isFull;
  assign overflow      = overflowReg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DEPTH_LOG2 = 4).
// Reference model: a queue of {break, parityError, data} entries, the expected
// acknowledge (a character is taken unless the previous cycle acknowledged one)
// and the sticky overflow bit.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [8:0]     rxData;
  logic           rxValid;
  logic           rxParityError;
  logic           rxBreak;
  logic           rxAck;
  logic [8:0]     rdData;
  logic           rdParityError;
  logic           rdBreak;
  logic           rdValid;
  logic           rdEnable;
  logic [DL2:0]   count;
  logic           full;
  logic           overflow;
  logic           clearOverflow;

  int checks = 0;
  int errors = 0;

  logic [10:0] refQ [$];
  bit          refAck;
  bit          refOv;

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxData        (rxData),
    .rxValid       (rxValid),
    .rxParityError (rxParityError),
    .rxBreak       (rxBreak),
    .rxAck         (rxAck),
    .rdData        (rdData),
    .rdParityError (rdParityError),
    .rdBreak       (rdBreak),
    .rdValid       (rdValid),
    .rdEnable      (rdEnable),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .clearOverflow (clearOverflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    refQ.delete();
    refAck = 1'b0;
    refOv  = 1'b0;
  endtask

  task automatic compareModel();
    logic [10:0] head;
    check("ack", 32'(rxAck), 32'(refAck));
    check("rdValid", 32'(rdValid), 32'(refQ.size() > 0));
    check("count", 32'(count), 32'(refQ.size()));
    check("full", 32'(full), 32'(refQ.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(refOv));
    if (refQ.size() > 0) begin
      head = refQ[0];
      check("rdData", 32'(rdData), 32'(head[8:0]));
      check("rdParityError", 32'(rdParityError), 32'(head[9]));
      check("rdBreak", 32'(rdBreak), 32'(head[10]));
    end
  endtask

  // One clock: drive inputs (called at negedge), update model at the edge,
  // compare just after it, return at the next negedge.
  task automatic step(input logic v, input logic [8:0] d, input logic pe,
                      input logic b, input logic rd, input logic clr);
    bit accept;
    bit popOk;
    bit space;
    logic [10:0] dummy;
    rxValid = v; rxData = d; rxParityError = pe; rxBreak = b;
    rdEnable = rd; clearOverflow = clr;
    @(posedge clk);
    accept = v && !refAck;
    popOk  = rd && (refQ.size() > 0);
    space  = (refQ.size() < DEPTH) || popOk;
    if (popOk) dummy = refQ.pop_front();
    if (accept && space) refQ.push_back({b, pe, d});
    if (accept && !space) refOv = 1'b1;
    else if (clr) refOv = 1'b0;
    refAck = accept;
    #1;
    if (accept || popOk)
      $display("txn t=%0t char=%0b data=0x%03h pe=%0b brk=%0b drop=%0b pop=%0b level=%0d",
               $time, accept, d, pe, b, accept && !space, popOk, refQ.size());
    compareModel();
    @(negedge clk);
  endtask

  task automatic sendChar(input logic [8:0] d, input logic pe, input logic b);
    step(1'b1, d, pe, b, 1'b0, 1'b0);
    step(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && refQ.size() > 0; i++)
      step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_count", 32'(count), 32'd0);
  endtask

  typedef struct {
    logic       v;
    logic [8:0] d;
    logic       pe;
    logic       b;
    logic       rd;
    logic       ack;
    logic       valid;
    int         cnt;
    logic [8:0] hd;
    logic       hpe;
    logic       hb;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [8:0] d;
    logic       lag;

    // Inputs, then expected rxAck, rdValid, count, head data/flags.
    tbl[0]  = '{1'b1, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h041, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 9'h041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 9'h041, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 9'h000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 9'h0AA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h0AA, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 9'h0AA, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 9'h0AA, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 9'h000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 9'h000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 9'h000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 9'h123, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 9'h123, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 9'h000, 1'b0, 1'b0};

    rst = 1'b0; rxValid = 1'b0; rxData = '0; rxParityError = 1'b0; rxBreak = 1'b0;
    rdEnable = 1'b0; clearOverflow = 1'b0;
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(rxAck), 32'd0);
    check("rst_rdValid", 32'(rdValid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rdData", 32'(rdData), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table: single char, receiver lag, flags per entry, empty pop
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].pe, tbl[i].b, tbl[i].rd, 1'b0);
      check($sformatf("tbl%0d_ack", i), 32'(rxAck), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_valid", i), 32'(rdValid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_data", i), 32'(rdData), 32'(tbl[i].hd));
        check($sformatf("tbl%0d_pe", i), 32'(rdParityError), 32'(tbl[i].hpe));
        check($sformatf("tbl%0d_brk", i), 32'(rdBreak), 32'(tbl[i].hb));
      end
    end

    // Fill to full, overflow on 17th, set-wins, clear, full with pop
    for (int i = 0; i < DEPTH; i++) sendChar(9'(i * 7 + 3), 1'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    step(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_ack", 32'(rxAck), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    step(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);
    step(1'b1, 9'h0F0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_setwins", 32'(overflow), 32'd1);
    step(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clear2", 32'(overflow), 32'd0);
    step(1'b1, 9'h155, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_count", 32'(count), 32'd16);
    check("fullpop_ack", 32'(rxAck), 32'd1);
    step(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // 40 chars with random receiver lag and frequent popping across wrap
    for (int i = 0; i < 40; i++) begin
      d   = 9'($urandom_range(0, 511));
      lag = 1'($urandom_range(0, 1));
      step(1'b1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'b0);
      step(lag, d, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    // Long random run with slow popping to reach full/overflow repeatedly
    for (int i = 0; i < 300; i++) begin
      d   = 9'($urandom_range(0, 511));
      lag = 1'($urandom_range(0, 1));
      step(1'b1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
      step(lag, d, 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
      for (int g = $urandom_range(0, 1); g > 0; g--)
        step(1'b0, 9'h0, 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    drain();

    // Reset mid-handshake with 5 entries stored
    for (int i = 0; i < 5; i++) sendChar(9'(i + 9'h010), 1'b0, 1'b0);
    step(1'b1, 9'h0AB, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_ack", 32'(rxAck), 32'd0);
    check("arst_rdValid", 32'(rdValid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_rdData", 32'(rdData), 32'd0);
    modelReset();
    rxValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sendChar(9'h0C3, 1'b0, 1'b0);
    check("post_rst_data", 32'(rdData), 32'h0C3);
    check("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_empty", 32'(rdValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. Consumes each received character (9-bit data plus parity-error and break flags) through the receiver's `dataReceived`/`receiveData` handshake and queues it in a first-word-fall-through FIFO. The host or bus side pops entries at its own pace and gets fill-level, empty/full and sticky overflow status.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 entries (legal 2..8).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronised by the parent.
- `rxData`  in  9  character from receiver (`dataOut`).
- `rxValid`  in  1  receiver `dataReceived`; level, held until acknowledged.
- `rxParityError`  in  1  receiver `parityError`, qualified by `rxValid`.
- `rxBreak`  in  1  receiver `break`, qualified by `rxValid`.
- `rxAck`  out  1  drives receiver `receiveData`; one-cycle pulse per consumed character.
- `rdData`  out  9  head entry data.
- `rdParityError`  out  1  head entry parity flag.
- `rdBreak`  out  1  head entry break flag.
- `rdValid`  out  1  FIFO non-empty; `rd*` outputs valid.
- `rdEnable`  in  1  pop head entry.
- `count`  out  DEPTH_LOG2+1  current fill level, 0..2^DEPTH_LOG2.
- `full`  out  1  count == depth.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.
- `clearOverflow`  in  1  clears `overflow`.

## Operation
- Entry = {break, parityError, data[8:0]}, 11 bits.
- Capture FSM, two states:
  - IDLE: if `rxValid`, assert `rxAck` for one cycle, push entry if space (see below), go to GUARD.
  - GUARD: `rxAck` low, `rxValid` ignored for this one cycle (receiver deasserts it the cycle after `rxAck`); return to IDLE.
- Every presented character is acknowledged, even when full; when full and no pop that cycle it is dropped and `overflow` set. Never stall the receiver.
- Pop: `rdEnable && rdValid` advances read pointer. `rdEnable` while empty is ignored, no error.
- Push and pop same cycle: both performed, `count` unchanged. Push when full with simultaneous pop is accepted (no overflow). Push when empty with `rdEnable` high: push only.
- Pointers DEPTH_LOG2 bits, wrap modulo depth; `count` tracked separately (+1 push, -1 pop).
- `overflow` set and `clearOverflow` same cycle: set wins.
- `rd*` are combinational reads of the head entry; contents undefined while `rdValid` low (drive zero is acceptable).

## Timing
- Reset values: `rxAck`=0, `rdValid`=0, `count`=0, `full`=0, `overflow`=0, `rd*` data/flags=0, FSM=IDLE, pointers=0.
- `rxValid` sampled high at edge N → `rxAck` high during cycle N..N+1 → `rdValid`/`count` updated after edge N (visible in the cycle following the capture edge, same cycle as `rxAck`).
- Maximum capture rate: one character per 2 cycles; far above any UART line rate.
- Pop at edge N → next entry (or `rdValid`=0) visible after edge N.
- Reset asserted mid-handshake: `rxAck` drops asynchronously; in-flight character is lost; FIFO empties.

## Structure
- Shared package `uart_pkg`: `UART_DATA_WIDTH`=9, `UART_RX_ENTRY_WIDTH`=11, entry field bit positions, parity-mode encodings (00 space, 11 mark, 01 even, 10 odd) shared with receiver/transmitter.
- One sub-module `fifo_mem`: simple dual-port register array, synchronous write, asynchronous read, parameterised width/depth; no reset on storage.
- Pointer/count/flag logic and capture FSM live in `uart_rx_fifo`.

## Test plan
- Reset release, single character 0x041 with no flags → one `rxAck` pulse; `rdValid`=1, `rdData`=0x041, `count`=1; pop → `rdValid`=0, `count`=0.
- Character with parity error then break character (data 0x000) → entries read back in order with `rdParityError`=1 then `rdBreak`=1, flags not crossing entries.
- Fill 16 entries (DEPTH_LOG2=4) → `full`=1, `count`=16; 17th char 0x1FF still acked, dropped, `overflow`=1; read-back yields original 16 only; `clearOverflow` → 0.
- Full FIFO, 17th char arrives in the same cycle as a pop → accepted, `overflow` stays 0, `count` stays 16.
- `rxValid` held high for 2 cycles per char (receiver lag) → exactly one push per character, no duplicates; 40 chars streamed with continuous popping across pointer wrap → data order intact.
- Assert `rst` low while `rxAck` high with 5 entries stored → all outputs to reset values immediately; after release first new char reads back alone.
